hub75_scan_sequencer: RTL and testbench

- Sequences one HUB75 panel refresh: fetches pixel pairs (top and bottom half) from the slice buffer and shifts each bit plane out over the HUB75 data lines.
- Drives the row address (A..E), shift clock, latch and OE_n.
- Uses binary-coded modulation (BCM): the display time of each plane is weighted by its bit significance.
- Sits between the theta-slice framebuffer and the panel pins; one frame_start_in pulse per rotational slice.

---
 rtl/hub75_scan_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_hub75_scan_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_sequencer.sv
// hub75_scan_sequencer
// Walks one HUB75 panel refresh: for every row and every BCM plane it fetches
// the top/bottom pixel pairs column by column, shifts the selected plane bit
// out on rgb0/rgb1 with hub_clk, blanks, latches, then shows the plane for a
// binary-weighted OE window (BASE_OE_CYCLES << plane).
// Optional build macro: HUB75_AUTO_REPEAT_EN -- when defined, a finished frame
// with no pending start immediately restarts at row 0 (busy stays high).
module hub75_scan_sequencer #(
  parameter int NUM_COLS       = 64,
  parameter int SCAN_RATE      = 32,
  parameter int COLOR_DEPTH    = 4,
  parameter int CLK_DIV        = 2,
  parameter int BASE_OE_CYCLES = 32,
  parameter int BLANK_CYCLES   = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          frame_start_in,
  output logic                          busy_out,
  output logic                          frame_done_out,
  output logic                          pix_req_out,
  output logic [$clog2(SCAN_RATE)-1:0]  pix_row_out,
  output logic [$clog2(NUM_COLS)-1:0]   pix_col_out,
  input  logic                          pix_valid_in,
  input  logic [3*COLOR_DEPTH-1:0]      rgb_top_in,
  input  logic [3*COLOR_DEPTH-1:0]      rgb_bot_in,
  output logic [2:0]                    rgb0_out,
  output logic [2:0]                    rgb1_out,
  output logic [$clog2(SCAN_RATE)-1:0]  addr_out,
  output logic                          hub_clk_out,
  output logic                          latch_out,
  output logic                          oe_n_out
);

  localparam int ROW_W  = $clog2(SCAN_RATE);
  localparam int COL_W  = $clog2(NUM_COLS);
  localparam int PL_W   = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
  localparam int PX_W   = 3 * COLOR_DEPTH;
  localparam int IX_W   = $clog2(PX_W);
  localparam int DISP_W = $clog2(BASE_OE_CYCLES << (COLOR_DEPTH - 1)) + 1;
  localparam int DIV_W  = $clog2(CLK_DIV) + 1;
  localparam int BLK_W  = $clog2(BLANK_CYCLES) + 1;
  localparam int CNT_A  = (DISP_W > DIV_W) ? DISP_W : DIV_W;
  localparam int CNT_W  = (CNT_A > BLK_W) ? CNT_A : BLK_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    BLANK    = 3'd4,
    LATCH    = 3'd5,
    DISPLAY  = 3'd6
  } state_t;

  // Pick bit `p` of each colour channel of a packed {R,G,B} pixel.
  function automatic logic [2:0] plane_bits(input logic [PX_W-1:0] px,
                                            input logic [PL_W-1:0] p);
    logic [IX_W-1:0] ix_r_s;
    logic [IX_W-1:0] ix_g_s;
    logic [IX_W-1:0] ix_b_s;
    ix_b_s = IX_W'(p);
    ix_g_s = IX_W'(COLOR_DEPTH) + IX_W'(p);
    ix_r_s = IX_W'(2 * COLOR_DEPTH) + IX_W'(p);
    return {px[ix_r_s], px[ix_g_s], px[ix_b_s]};
  endfunction

  state_t           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [ROW_W-1:0] row_q,        row_d;
  logic [COL_W-1:0] col_q,        col_d;
  logic [PL_W-1:0]  plane_q,      plane_d;
  logic             pending_q,    pending_d;
  logic [2:0]       rgb0_q,       rgb0_d;
  logic [2:0]       rgb1_q,       rgb1_d;
  logic [ROW_W-1:0] addr_q,       addr_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q,       busy_d;
  logic             pix_req_q,    pix_req_d;
  logic             hub_clk_q,    hub_clk_d;
  logic             latch_q,      latch_d;
  logic             oe_n_q,       oe_n_d;

  logic [CNT_W-1:0] disp_len_s;

  assign disp_len_s = CNT_W'(BASE_OE_CYCLES) << plane_q;

  // Next-state, loop counters and next registered-output values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    plane_d      = plane_q;
    pending_d    = pending_q;
    rgb0_d       = rgb0_q;
    rgb1_d       = rgb1_q;
    addr_d       = addr_q;
    frame_done_d = 1'b0;

    // A start while a frame is running is remembered once; extras are dropped.
    if (frame_start_in && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    case (state_q)
      IDLE: begin
        if (frame_start_in || pending_q) begin
          state_d   = FETCH;
          row_d     = '0;
          col_d     = '0;
          plane_d   = '0;
          cnt_d     = '0;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (pix_valid_in) begin
          rgb0_d  = plane_bits(rgb_top_in, plane_q);
          rgb1_d  = plane_bits(rgb_bot_in, plane_q);
          cnt_d   = '0;
          state_d = SHIFT_LO;
        end else begin
          state_d = FETCH;
        end
      end
      SHIFT_LO: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT_HI: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (col_q == COL_W'(NUM_COLS - 1)) begin
            addr_d  = row_q;
            state_d = BLANK;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = FETCH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = LATCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LATCH: begin
        cnt_d   = '0;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        if (cnt_q == (disp_len_s - CNT_W'(1))) begin
          cnt_d = '0;
          col_d = '0;
          if (plane_q != PL_W'(COLOR_DEPTH - 1)) begin
            plane_d = plane_q + PL_W'(1);
            state_d = FETCH;
          end else if (row_q != ROW_W'(SCAN_RATE - 1)) begin
            plane_d = '0;
            row_d   = row_q + ROW_W'(1);
            state_d = FETCH;
          end else begin
            // Frame complete; a start arriving on this very cycle still counts.
            plane_d      = '0;
            row_d        = '0;
            frame_done_d = 1'b1;
            pending_d    = 1'b0;
            if (pending_q || frame_start_in) begin
              state_d = FETCH;
            end else begin
`ifdef HUB75_AUTO_REPEAT_EN
              state_d = FETCH;
`else
              state_d = IDLE;
`endif
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase

    busy_d    = (state_d != IDLE);
    pix_req_d = (state_d == FETCH);
    hub_clk_d = (state_d == SHIFT_HI);
    latch_d   = (state_d == LATCH);
    oe_n_d    = (state_d != DISPLAY);
  end

  // State and every output flop; reset leaves the panel dark (OE_n high).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      plane_q      <= '0;
      pending_q    <= 1'b0;
      rgb0_q       <= 3'b000;
      rgb1_q       <= 3'b000;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      pix_req_q    <= 1'b0;
      hub_clk_q    <= 1'b0;
      latch_q      <= 1'b0;
      oe_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      plane_q      <= plane_d;
      pending_q    <= pending_d;
      rgb0_q       <= rgb0_d;
      rgb1_q       <= rgb1_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      pix_req_q    <= pix_req_d;
      hub_clk_q    <= hub_clk_d;
      latch_q      <= latch_d;
      oe_n_q       <= oe_n_d;
    end
  end

  assign busy_out       = busy_q;
  assign frame_done_out = frame_done_q;
  assign pix_req_out    = pix_req_q;
  assign pix_row_out    = row_q;
  assign pix_col_out    = col_q;
  assign rgb0_out       = rgb0_q;
  assign rgb1_out       = rgb1_q;
  assign addr_out       = addr_q;
  assign hub_clk_out    = hub_clk_q;
  assign latch_out      = latch_q;
  assign oe_n_out       = oe_n_q;

endmodule

// File: tb/tb_hub75_scan_sequencer.sv
// Scoreboard bench for hub75_scan_sequencer with a small 4x(2x2) panel.
module tb_hub75_scan_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       frame_start_in;
  logic       busy_out;
  logic       frame_done_out;
  logic       pix_req_out;
  logic [0:0] pix_row_out;
  logic [1:0] pix_col_out;
  logic       pix_valid_in;
  logic [5:0] rgb_top_in;
  logic [5:0] rgb_bot_in;
  logic [2:0] rgb0_out;
  logic [2:0] rgb1_out;
  logic [0:0] addr_out;
  logic       hub_clk_out;
  logic       latch_out;
  logic       oe_n_out;

  hub75_scan_sequencer #(
    .NUM_COLS(4), .SCAN_RATE(2), .COLOR_DEPTH(2),
    .CLK_DIV(1), .BASE_OE_CYCLES(4), .BLANK_CYCLES(1)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .busy_out(busy_out), .frame_done_out(frame_done_out),
    .pix_req_out(pix_req_out), .pix_row_out(pix_row_out),
    .pix_col_out(pix_col_out), .pix_valid_in(pix_valid_in),
    .rgb_top_in(rgb_top_in), .rgb_bot_in(rgb_bot_in),
    .rgb0_out(rgb0_out), .rgb1_out(rgb1_out), .addr_out(addr_out),
    .hub_clk_out(hub_clk_out), .latch_out(latch_out), .oe_n_out(oe_n_out)
  );

  always #5 clk_in = ~clk_in;

  // Pixel table indexed row*4+col, with hand-derived plane bits {rgb0,rgb1}.
  localparam logic [5:0] TOP_TAB [8] = '{6'b11_00_00, 6'b01_01_01, 6'b10_01_11, 6'b00_11_00,
                                         6'b10_00_01, 6'b00_00_00, 6'b11_11_11, 6'b01_10_11};
  localparam logic [5:0] BOT_TAB [8] = '{6'b00_00_11, 6'b10_10_10, 6'b01_10_00, 6'b11_11_11,
                                         6'b00_10_00, 6'b01_00_10, 6'b00_00_00, 6'b10_01_00};
  localparam logic [5:0] EXP_P0 [8]  = '{6'b100_001, 6'b111_000, 6'b011_100, 6'b010_111,
                                         6'b001_000, 6'b000_100, 6'b111_000, 6'b101_010};
  localparam logic [5:0] EXP_P1 [8]  = '{6'b100_001, 6'b000_111, 6'b101_010, 6'b010_111,
                                         6'b100_010, 6'b000_001, 6'b111_000, 6'b011_100};

  typedef struct packed {
    logic [0:0] row;
    logic [1:0] col;
    logic [5:0] rgb;
  } shift_exp_t;

  typedef struct packed {
    logic [0:0] row;
    logic [4:0] len;
  } disp_exp_t;

  shift_exp_t shift_q[$];
  disp_exp_t  disp_q[$];
  int errors = 0;
  int checks = 0;
  logic stall_armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue the expected shift data and display windows of one frame.
  task automatic push_frame();
    shift_exp_t s;
    disp_exp_t  d;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 2; p++) begin
        for (int c = 0; c < 4; c++) begin
          s.row = 1'(r);
          s.col = 2'(c);
          s.rgb = (p == 0) ? EXP_P0[r*4+c] : EXP_P1[r*4+c];
          shift_q.push_back(s);
        end
        d.row = 1'(r);
        d.len = (p == 0) ? 5'd4 : 5'd8;
        disp_q.push_back(d);
      end
    end
  endtask

  // Fetch responder: valid one cycle after the request, or ten when stalled.
  initial begin
    int wait_cnt;
    int delay;
    int idx;
    pix_valid_in = 1'b0;
    rgb_top_in   = 6'b101010;
    rgb_bot_in   = 6'b010101;
    wait_cnt     = 0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        pix_valid_in = 1'b0;
        wait_cnt     = 0;
      end else if (pix_valid_in) begin
        pix_valid_in = 1'b0;
        rgb_top_in   = 6'b101010;
        rgb_bot_in   = 6'b010101;
      end else if (pix_req_out) begin
        delay = (stall_armed && pix_col_out == 2'd1) ? 10 : 1;
        if (delay == 10) begin
          check("stall_col_held", pix_col_out, 2'd1);
          check("stall_hub_clk_low", hub_clk_out, 1'b0);
        end
        if (wait_cnt == delay) begin
          idx          = int'(pix_row_out) * 4 + int'(pix_col_out);
          rgb_top_in   = TOP_TAB[idx];
          rgb_bot_in   = BOT_TAB[idx];
          pix_valid_in = 1'b1;
          wait_cnt     = 0;
          if (delay == 10) stall_armed = 1'b0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Monitor: pops expectations on hub_clk rises and latch pulses, times OE windows.
  initial begin
    logic       prev_hub;
    logic       prev_oe;
    logic [0:0] prev_addr;
    int         low_cnt;
    int         cur_len;
    shift_exp_t s;
    disp_exp_t  d;
    prev_hub = 1'b0; prev_oe = 1'b1; prev_addr = 1'b0; low_cnt = 0; cur_len = 0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        prev_hub = 1'b0; prev_oe = 1'b1; prev_addr = 1'b0; low_cnt = 0; cur_len = 0;
      end else begin
        if (hub_clk_out && !prev_hub) begin
          if (shift_q.size() == 0) begin
            check("unexpected_shift", 32'd1, 32'd0);
          end else begin
            s = shift_q.pop_front();
            check("shift_pos", {pix_row_out, pix_col_out}, {s.row, s.col});
            check("shift_data", {rgb0_out, rgb1_out}, s.rgb);
          end
        end
        if (latch_out) begin
          check("oe_n_during_latch", oe_n_out, 1'b1);
          if (disp_q.size() == 0) begin
            check("unexpected_latch", 32'd1, 32'd0);
          end else begin
            d = disp_q.pop_front();
            check("latch_addr", addr_out, d.row);
            check("blank_before_latch", {prev_oe, prev_addr}, {1'b1, d.row});
            cur_len = int'(d.len);
          end
        end
        if (!oe_n_out) begin
          low_cnt++;
        end else if (!prev_oe) begin
          check("display_len", low_cnt, cur_len);
          low_cnt = 0;
        end
        prev_hub  = hub_clk_out;
        prev_oe   = oe_n_out;
        prev_addr = addr_out;
      end
    end
  end

  // Start a run, optionally pulsing extra starts at given busy-cycle numbers.
  task automatic run_frames(input int nframes, input int pulse_a, input int pulse_b,
                            input int exp_busy, input string tag);
    int   cnt;
    int   fd;
    int   rises;
    int   guard;
    logic prev_h;
    cnt = 0; fd = 0; rises = 0; guard = 0; prev_h = 1'b0;
    for (int f = 0; f < nframes; f++) push_frame();
    @(negedge clk_in) frame_start_in = 1'b1;
    @(negedge clk_in) frame_start_in = 1'b0;
    while ((busy_out || cnt == 0) && guard < 3000) begin
      if (busy_out) cnt++;
      frame_start_in = (pulse_a != 0 && cnt == pulse_a) || (pulse_b != 0 && cnt == pulse_b);
      if (frame_done_out) begin
        fd++;
        if (fd < nframes) begin
          check({tag, "_restart_in_fetch"}, {busy_out, pix_req_out}, 2'b11);
        end
      end
      if (hub_clk_out && !prev_h) rises++;
      prev_h = hub_clk_out;
      guard++;
      @(negedge clk_in);
    end
    frame_start_in = 1'b0;
    if (frame_done_out) fd++;
    check({tag, "_timeout"}, (guard >= 3000), 1'b0);
    check({tag, "_busy_cycles"}, cnt, exp_busy);
    check({tag, "_frame_done_pulses"}, fd, nframes);
    check({tag, "_hub_clk_rises"}, rises, 16 * nframes);
    check({tag, "_shift_queue_empty"}, shift_q.size(), 0);
    check({tag, "_disp_queue_empty"}, disp_q.size(), 0);
    repeat (6) @(negedge clk_in);
    check({tag, "_idle_after"}, {busy_out, oe_n_out, pix_req_out}, 3'b010);
  endtask

  initial begin
    int guard;
    int busy_seen;
    rst_in = 1'b1;
    frame_start_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_oe_n", oe_n_out, 1'b1);
    check("reset_ctrl", {busy_out, frame_done_out, pix_req_out, hub_clk_out, latch_out}, 5'b0);
    check("reset_data", {rgb0_out, rgb1_out, addr_out}, 7'b0);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check("idle_after_reset", {busy_out, oe_n_out}, 2'b01);

    run_frames(1, 0, 0, 96, "single");
    stall_armed = 1'b1;
    run_frames(1, 0, 0, 105, "stall");
    run_frames(2, 20, 30, 192, "double_start");
    run_frames(2, 96, 0, 192, "start_on_last_cycle");

    // Reset during row-1 display, with a start already pending.
    push_frame();
    @(negedge clk_in) frame_start_in = 1'b1;
    @(negedge clk_in) frame_start_in = 1'b0;
    repeat (3) @(negedge clk_in);
    frame_start_in = 1'b1;
    @(negedge clk_in) frame_start_in = 1'b0;
    guard = 0;
    while (!(latch_out && addr_out == 1'b1) && guard < 500) begin
      guard++;
      @(negedge clk_in);
    end
    check("reach_row1_latch", (guard >= 500), 1'b0);
    @(negedge clk_in);
    @(negedge clk_in);
    check("in_row1_display", {oe_n_out, busy_out}, 2'b01);
    rst_in = 1'b1;
    #1;
    check("rst_oe_n", oe_n_out, 1'b1);
    check("rst_latch_req_busy", {latch_out, pix_req_out, busy_out}, 3'b000);
    @(negedge clk_in);
    shift_q.delete();
    disp_q.delete();
    @(negedge clk_in) rst_in = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_in);
      if (busy_out || pix_req_out) busy_seen++;
    end
    check("pending_cleared_by_reset", busy_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
